// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: word geometry, FSM
// state encoding and the access error check.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // True when a byte address is not word aligned or falls beyond the array.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int unsigned       depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder: synchronous write with
// per-byte-lane enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [LANES-1:0]  be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Byte-lane write and registered read, both on the access edge.
  // NOTE: the array has no reset so it maps onto RAM macros, and every
  // register here takes <= so reads see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready slave for the core's load/store port,
// one transaction outstanding, WAIT_CYCLES+1 edges from accept to response.
// Optional build macro: DMEM_BYTE_STROBE_EN adds req_be byte-lane strobes.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [LANES-1:0]  req_be,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_e            state;
  logic [3:0]        cnt;
  logic              lat_write;
  logic [WORD_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_wdata;
  logic [LANES-1:0]  lat_be;
  logic              rsp_err_q;
  logic              rsp_load_q;

  logic              access;
  logic              acc_err;
  logic              arr_we;
  logic              arr_re;
  logic [WORD_W-1:0] arr_rdata;

  // The access edge is the last WAIT edge; a zero wait still spends one
  // cycle in WAIT so the response always trails the accept by WAIT_CYCLES+1.
  assign access  = (state == WAIT) && (cnt == '0);
  assign acc_err = addr_err(lat_addr, DEPTH);
  assign arr_we  = access && lat_write && !acc_err;
  assign arr_re  = access && !lat_write && !acc_err;

  // Handshake outputs decode registered state only.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_load_q ? arr_rdata : '0;

`ifndef DMEM_BYTE_STROBE_EN
  assign lat_be = '1;
`endif

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .be    (lat_be),
    .addr  (lat_addr[AW+1:2]),
    .wdata (lat_wdata),
    .rdata (arr_rdata)
  );

  // Request latch, wait countdown and response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
`ifdef DMEM_BYTE_STROBE_EN
      lat_be     <= '0;
`endif
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
            lat_be    <= req_be;
`endif
            cnt       <= 4'(WAIT_CYCLES);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_err_q  <= acc_err;
            rsp_load_q <= !lat_write && !acc_err;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A (DEPTH=256, WAIT_CYCLES=2)
// and instance B (DEPTH=4, WAIT_CYCLES=0), selected by sel.
module tb_dmem_responder;

  typedef struct {
    logic        sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  req_be = 4'hF;
`endif

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err;
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] a_rsp_rdata, b_rsp_rdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  assign a_req_valid = req_valid && !sel;
  assign b_req_valid = req_valid && sel;
  assign req_ready   = sel ? b_req_ready : a_req_ready;
  assign rsp_valid   = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_err     = sel ? b_rsp_err   : a_rsp_err;
  assign rsp_rdata   = sel ? b_rsp_rdata : a_rsp_rdata;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be    (req_be),
`endif
    .rsp_valid (a_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err)
  );

  dmem_responder #(.DEPTH(4), .WAIT_CYCLES(0)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be    (req_be),
`endif
    .rsp_valid (b_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_rdata, input logic exp_err, input string name);
    vec_t v;
    v.sel = s; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({name, " rsp_rdata"}, rsp_rdata, 32'd0);
    check({name, " rsp_err"},   32'(rsp_err),   32'd0);
    check({name, " req_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Wait (bounded) for rsp_valid; returns edges counted since the accept edge.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full transaction: accept, latency, response contents, release.
  task automatic run_txn(input vec_t v);
    int lat;
    sel = v.sel; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
`ifdef DMEM_BYTE_STROBE_EN
    req_be = v.be;
`endif
    req_valid = 1'b1;
    #1;
    check({v.name, " req_ready@req"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    check({v.name, " latency"},   32'(lat), v.sel ? 32'd1 : 32'd3);
    check({v.name, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({v.name, " rsp_err"},   32'(rsp_err), 32'(v.exp_err));
    check({v.name, " req_ready@rsp"}, 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_idle_outputs({v.name, " post"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vec_t v;

    add(0, 1, 32'h10,  32'hDEAD_BEEF, 4'hF, 32'h0,         0, "a_st_10");
    add(0, 0, 32'h10,  32'h0,         4'hF, 32'hDEAD_BEEF, 0, "a_ld_10");
    add(0, 1, 32'h0,   32'h0BAD_F00D, 4'hF, 32'h0,         0, "a_st_0");
    add(0, 0, 32'h13,  32'h0,         4'hF, 32'h0,         1, "a_ld_misaligned");
    add(0, 1, 32'h400, 32'h1111_1111, 4'hF, 32'h0,         1, "a_st_range");
    add(0, 1, 32'h2,   32'h2222_2222, 4'hF, 32'h0,         1, "a_st_misaligned");
    add(0, 0, 32'h0,   32'h0,         4'hF, 32'h0BAD_F00D, 0, "a_ld_0");
    add(0, 1, 32'h3FC, 32'hCAFE_0001, 4'hF, 32'h0,         0, "a_st_last");
    add(0, 0, 32'h3FC, 32'h0,         4'hF, 32'hCAFE_0001, 0, "a_ld_last");
    add(0, 1, 32'h20,  32'h0000_5555, 4'hF, 32'h0,         0, "a_st_20");
    add(1, 1, 32'h4,   32'h0000_000A, 4'hF, 32'h0,         0, "b_st_4");
    add(1, 0, 32'h4,   32'h0,         4'hF, 32'h0000_000A, 0, "b_ld_4");
    add(1, 1, 32'h10,  32'h3333_3333, 4'hF, 32'h0,         1, "b_st_range");
    add(1, 1, 32'hC,   32'h0000_0077, 4'hF, 32'h0,         0, "b_st_c");
    add(1, 0, 32'hC,   32'h0,         4'hF, 32'h0000_0077, 0, "b_ld_c");
    add(1, 0, 32'h4,   32'h0,         4'hF, 32'h0000_000A, 0, "b_ld_4_again");
`ifdef DMEM_BYTE_STROBE_EN
    add(0, 1, 32'h8,   32'hFFFF_FFFF, 4'hF, 32'h0,         0, "be_st_all");
    add(0, 1, 32'h8,   32'h0000_0000, 4'h5, 32'h0,         0, "be_st_0101");
    add(0, 0, 32'h8,   32'h0,         4'h0, 32'hFF00_FF00, 0, "be_ld");
    add(0, 1, 32'h8,   32'h1234_5678, 4'h0, 32'h0,         0, "be_st_none");
    add(0, 0, 32'h8,   32'h0,         4'h3, 32'hFF00_FF00, 0, "be_ld_after_none");
`endif

    // Reset state.
    #12;
    check_idle_outputs("reset_a");
    sel = 1'b1; #1;
    check_idle_outputs("reset_b");
    sel = 1'b0;
    #7 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Response stall: outputs hold, a competing request is not accepted.
    sel = 1'b0; req_write = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    check("stall rsp_valid", 32'(rsp_valid), 32'd1);
    req_write = 1'b1; req_wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall hold rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall hold rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("stall hold req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_idle_outputs("stall release");
    v.sel = 0; v.wr = 0; v.addr = 32'h10; v.wdata = 0; v.be = 4'hF;
    v.exp_rdata = 32'hDEAD_BEEF; v.exp_err = 0; v.name = "stall_reload";
    run_txn(v);

    // Reset one cycle after accepting a store: store is dropped.
    sel = 1'b0; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h0000_1234;
`ifdef DMEM_BYTE_STROBE_EN
    req_be = 4'hF;
`endif
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    v.sel = 0; v.wr = 0; v.addr = 32'h20; v.wdata = 0; v.be = 4'hF;
    v.exp_rdata = 32'h0000_5555; v.exp_err = 0; v.name = "midreset_ld_20";
    run_txn(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
